// File: rtl/ex_divider.sv
// Multi-cycle radix-2 restoring divider for the EX stage (MIPS DIV/DIVU).
// Holds the front of the pipeline while busy and emits quotient/remainder for HI/LO writeback.
module ex_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_start,
  input  logic             ex_signed,
  input  logic [WIDTH-1:0] ex_operand_a,
  input  logic [WIDTH-1:0] ex_operand_b,
  input  logic             ex_cancel,
  output logic             stall_request,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_quotient,
  output logic [WIDTH-1:0] result_remainder,
  output logic             divide_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [CW-1:0]    counter_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic             start_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] rem_next_s;

  // Two's-complement negate, used both for operand magnitude and result sign fix-up.
  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE_VAL) : v;
  endfunction

  // Start qualification: a flush in the same cycle kills the request.
  always_comb begin
    start_s = ex_start & ~ex_cancel;
  end

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = shifted_s - {1'b0, div_r};
    quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    rem_next_s = shifted_s[WIDTH-1:0];
    if (trial_s[WIDTH]) begin
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      rem_next_s = shifted_s[WIDTH-1:0];
    end else begin
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
      rem_next_s = trial_s[WIDTH-1:0];
    end
  end

  // Pipeline hold: low in DONE so the result cycle lets the pipeline advance.
  always_comb begin
    stall_request = 1'b0;
    case (state_r)
      IDLE:    stall_request = start_s;
      BUSY:    stall_request = ~ex_cancel;
      DONE:    stall_request = 1'b0;
      default: stall_request = 1'b0;
    endcase
  end

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      counter_r        <= {CW{1'b0}};
      quo_r            <= {WIDTH{1'b0}};
      rem_r            <= {WIDTH{1'b0}};
      div_r            <= {WIDTH{1'b0}};
      neg_q_r          <= 1'b0;
      neg_r_r          <= 1'b0;
      result_valid     <= 1'b0;
      result_quotient  <= {WIDTH{1'b0}};
      result_remainder <= {WIDTH{1'b0}};
      divide_by_zero   <= 1'b0;
    end else begin
      result_valid   <= 1'b0;
      divide_by_zero <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            if (ex_operand_b == {WIDTH{1'b0}}) begin
              state_r          <= DONE;
              result_valid     <= 1'b1;
              divide_by_zero   <= 1'b1;
              result_quotient  <= {WIDTH{1'b1}};
              result_remainder <= ex_operand_a;
            end else begin
              state_r   <= BUSY;
              counter_r <= {CW{1'b0}};
              rem_r     <= {WIDTH{1'b0}};
              quo_r     <= negate_if(ex_operand_a, ex_signed & ex_operand_a[WIDTH-1]);
              div_r     <= negate_if(ex_operand_b, ex_signed & ex_operand_b[WIDTH-1]);
              neg_q_r   <= ex_signed & (ex_operand_a[WIDTH-1] ^ ex_operand_b[WIDTH-1]);
              neg_r_r   <= ex_signed & ex_operand_a[WIDTH-1];
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (ex_cancel) begin
            state_r <= IDLE;
          end else begin
            quo_r     <= quo_next_s;
            rem_r     <= rem_next_s;
            counter_r <= counter_r + CW'(1);
            if (counter_r == LAST_STEP) begin
              state_r          <= DONE;
              result_valid     <= 1'b1;
              result_quotient  <= negate_if(quo_next_s, neg_q_r);
              result_remainder <= negate_if(rem_next_s, neg_r_r);
            end else begin
              state_r <= BUSY;
            end
          end
        end
        DONE: begin
          // ex_start still reflects the instruction being retired; do not restart on it.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider: latency, stall shape, signed fix-up,
// zero divisor, cancel, reset mid-operation and back-to-back operations.
module tb_ex_divider;

  logic        clock;
  logic        reset;
  logic        ex_start;
  logic        ex_signed;
  logic [31:0] ex_operand_a;
  logic [31:0] ex_operand_b;
  logic        ex_cancel;
  logic        stall_request;
  logic        result_valid;
  logic [31:0] result_quotient;
  logic [31:0] result_remainder;
  logic        divide_by_zero;

  int checks;
  int failures;

  ex_divider #(.WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_start         (ex_start),
    .ex_signed        (ex_signed),
    .ex_operand_a     (ex_operand_a),
    .ex_operand_b     (ex_operand_b),
    .ex_cancel        (ex_cancel),
    .stall_request    (stall_request),
    .result_valid     (result_valid),
    .result_quotient  (result_quotient),
    .result_remainder (result_remainder),
    .divide_by_zero   (divide_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observations from the most recent operation (driver only, no checking here).
  int          obs_lat;
  int          obs_stalls;
  logic        obs_start_stall;
  logic        obs_stall_at_valid;
  logic [31:0] obs_q;
  logic [31:0] obs_r;
  logic        obs_dbz;
  logic        obs_valid_after;

  // Entered 1 time unit after a rising edge; leaves in the IDLE cycle after the result with ex_start low.
  task automatic issue_and_wait(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bit found;
    found = 1'b0;
    obs_lat = -1; obs_stalls = 0; obs_q = 32'h0; obs_r = 32'h0; obs_dbz = 1'b0;
    obs_stall_at_valid = 1'b1;
    ex_signed = sgn; ex_operand_a = a; ex_operand_b = b; ex_start = 1'b1;
    #1 obs_start_stall = stall_request;
    for (int c = 1; c <= 40; c++) begin
      if (!found) begin
        @(posedge clock); #1;
        if (result_valid) begin
          found = 1'b1;
          obs_lat = c; obs_q = result_quotient; obs_r = result_remainder;
          obs_dbz = divide_by_zero; obs_stall_at_valid = stall_request;
        end else if (stall_request) begin
          obs_stalls++;
        end
      end
    end
    @(posedge clock); #1;
    ex_start = 1'b0;
    #1 obs_valid_after = result_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1; ex_start = 1'b0; ex_cancel = 1'b0; ex_signed = 1'b0;
    ex_operand_a = 32'h0; ex_operand_b = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", result_valid); end
    checks++; if (result_quotient !== 32'h0) begin failures++; $display("FAIL reset_q got %h want 0", result_quotient); end
    checks++; if (result_remainder !== 32'h0) begin failures++; $display("FAIL reset_r got %h want 0", result_remainder); end
    checks++; if (divide_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got %b want 0", divide_by_zero); end
    checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall_request); end
  endtask

  task automatic test_divu_basic;
    issue_and_wait(1'b0, 32'd100, 32'd7);
    checks++; if (obs_lat !== 33) begin failures++; $display("FAIL divu_latency got %0d want 33", obs_lat); end
    checks++; if (obs_start_stall !== 1'b1) begin failures++; $display("FAIL divu_start_stall got %b want 1", obs_start_stall); end
    checks++; if (obs_stalls !== 32) begin failures++; $display("FAIL divu_stall_cycles got %0d want 32", obs_stalls); end
    checks++; if (obs_stall_at_valid !== 1'b0) begin failures++; $display("FAIL divu_stall_in_done got %b want 0", obs_stall_at_valid); end
    checks++; if (obs_q !== 32'd14) begin failures++; $display("FAIL divu_q got %h want %h", obs_q, 32'd14); end
    checks++; if (obs_r !== 32'd2) begin failures++; $display("FAIL divu_r got %h want %h", obs_r, 32'd2); end
    checks++; if (obs_dbz !== 1'b0) begin failures++; $display("FAIL divu_dbz got %b want 0", obs_dbz); end
    checks++; if (obs_valid_after !== 1'b0) begin failures++; $display("FAIL divu_valid_pulse got %b want 0", obs_valid_after); end
    checks++; if (result_quotient !== 32'd14) begin failures++; $display("FAIL divu_q_hold got %h want %h", result_quotient, 32'd14); end
  endtask

  task automatic test_signed;
    issue_and_wait(1'b1, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
    checks++; if (obs_q !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2_q got %h want fffffffd", obs_q); end
    checks++; if (obs_r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_m7_2_r got %h want ffffffff", obs_r); end
    issue_and_wait(1'b1, 32'd7, 32'hFFFF_FFFE);   // 7 / -2
    checks++; if (obs_q !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2_q got %h want fffffffd", obs_q); end
    checks++; if (obs_r !== 32'd1) begin failures++; $display("FAIL div_7_m2_r got %h want 1", obs_r); end
    issue_and_wait(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if (obs_q !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_q got %h want 80000000", obs_q); end
    checks++; if (obs_r !== 32'h0) begin failures++; $display("FAIL div_ovf_r got %h want 0", obs_r); end
    checks++; if (obs_dbz !== 1'b0) begin failures++; $display("FAIL div_ovf_dbz got %b want 0", obs_dbz); end
    checks++; if (obs_lat !== 33) begin failures++; $display("FAIL div_ovf_latency got %0d want 33", obs_lat); end
  endtask

  task automatic test_div_by_zero;
    issue_and_wait(1'b0, 32'd5, 32'd0);
    checks++; if (obs_lat !== 1) begin failures++; $display("FAIL dbz_latency got %0d want 1", obs_lat); end
    checks++; if (obs_q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_q got %h want ffffffff", obs_q); end
    checks++; if (obs_r !== 32'd5) begin failures++; $display("FAIL dbz_r got %h want 5", obs_r); end
    checks++; if (obs_dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag got %b want 1", obs_dbz); end
    checks++; if (obs_stall_at_valid !== 1'b0) begin failures++; $display("FAIL dbz_stall_in_done got %b want 0", obs_stall_at_valid); end
    #1;
    checks++; if (divide_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_flag_clear got %b want 0", divide_by_zero); end
  endtask

  task automatic test_cancel;
    int pulses;
    pulses = 0;
    ex_signed = 1'b0; ex_operand_a = 32'd1000; ex_operand_b = 32'd3; ex_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (result_valid) pulses++;
    end
    ex_cancel = 1'b1;
    #1;
    checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL cancel_stall_drop got %b want 0", stall_request); end
    @(posedge clock); #1;
    ex_cancel = 1'b0; ex_start = 1'b0;
    #1;
    checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL cancel_idle_stall got %b want 0", stall_request); end
    for (int c = 0; c < 40; c++) begin
      if (result_valid) pulses++;
      @(posedge clock); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL cancel_no_valid got %0d pulses want 0", pulses); end
    issue_and_wait(1'b0, 32'd9, 32'd4);
    checks++; if (obs_lat !== 33) begin failures++; $display("FAIL after_cancel_latency got %0d want 33", obs_lat); end
    checks++; if (obs_q !== 32'd2) begin failures++; $display("FAIL after_cancel_q got %h want 2", obs_q); end
    checks++; if (obs_r !== 32'd1) begin failures++; $display("FAIL after_cancel_r got %h want 1", obs_r); end
  endtask

  task automatic test_reset_mid_busy;
    int pulses;
    pulses = 0;
    ex_signed = 1'b0; ex_operand_a = 32'hFFFF_FFFF; ex_operand_b = 32'h10; ex_start = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1; ex_start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got %b want 0", result_valid); end
    checks++; if (result_quotient !== 32'h0) begin failures++; $display("FAIL midreset_q got %h want 0", result_quotient); end
    checks++; if (result_remainder !== 32'h0) begin failures++; $display("FAIL midreset_r got %h want 0", result_remainder); end
    checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL midreset_stall got %b want 0", stall_request); end
    for (int c = 0; c < 40; c++) begin
      if (result_valid) pulses++;
      @(posedge clock); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_no_valid got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back;
    issue_and_wait(1'b0, 32'hFFFF_FFFF, 32'h10);
    checks++; if (obs_lat !== 33) begin failures++; $display("FAIL b2b_first_latency got %0d want 33", obs_lat); end
    checks++; if (obs_q !== 32'h0FFF_FFFF) begin failures++; $display("FAIL b2b_first_q got %h want 0fffffff", obs_q); end
    checks++; if (obs_r !== 32'hF) begin failures++; $display("FAIL b2b_first_r got %h want f", obs_r); end
    checks++; if (obs_valid_after !== 1'b0) begin failures++; $display("FAIL b2b_first_pulse got %b want 0", obs_valid_after); end
    issue_and_wait(1'b0, 32'd12, 32'd12);
    checks++; if (obs_start_stall !== 1'b1) begin failures++; $display("FAIL b2b_second_start got %b want 1", obs_start_stall); end
    checks++; if (obs_lat !== 33) begin failures++; $display("FAIL b2b_second_latency got %0d want 33", obs_lat); end
    checks++; if (obs_q !== 32'd1) begin failures++; $display("FAIL b2b_second_q got %h want 1", obs_q); end
    checks++; if (obs_r !== 32'd0) begin failures++; $display("FAIL b2b_second_r got %h want 0", obs_r); end
    checks++; if (obs_valid_after !== 1'b0) begin failures++; $display("FAIL b2b_second_pulse got %b want 0", obs_valid_after); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_cancel();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
